reg_bank_param: RTL

Parametrised configuration register bank, the next generation of the system register file. It stores 2**ADDR_WIDTH words of DATA_WIDTH bits and provides per-register reset values and per-register write protection. Reads use a pipeline of configurable latency; a simultaneous read and write both complete in the same cycle. It sits between the command-decode/control FSM and the datapath blocks, and exports its low-address registers as static configuration.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_param_if.sv | 36 +++
 rtl/reg_rd_pipe.sv | 55 +++++
 rtl/reg_bank_param.sv | 92 +++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared defaults and helpers for the parametrised configuration register bank.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF / NUM_EXPORT_DEF : default geometry
//   depth(aw)                                        : number of words for aw address bits
//   RST_VALS_DEF                                     : default per-word reset image
//                                                      (word 2 = 8'h81, word 3 = 8'h20)
package reg_bank_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_EXPORT_DEF = 4;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    // Word k lives at bits [k*DATA_WIDTH_DEF +: DATA_WIDTH_DEF].
    localparam logic [(1 << ADDR_WIDTH_DEF)*DATA_WIDTH_DEF-1:0] RST_VALS_DEF =
        128'h0000_0000_0000_0000_0000_0000_2081_0000;

endpackage

// File: rtl/reg_bank_param_if.sv
// reg_bank_param_if
// Bus between the command-decode/control side (master) and the register bank (slave).
//   i_Address      : word address shared by read and write
//   i_WrEn/i_WrData: write request and data
//   i_RdEn         : read request
//   o_RdData/o_RdData_valid : read return and its one-cycle strobe
//   o_err          : one-cycle strobe, write to a read-only word rejected
//   o_regs         : exported low words, word 0 in the LSBs
//   o_reg_upd      : one-cycle per-exported-word write strobe
interface reg_bank_param_if
    import reg_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_EXPORT = NUM_EXPORT_DEF
);
    logic [ADDR_WIDTH-1:0]            i_Address;
    logic                             i_WrEn;
    logic                             i_RdEn;
    logic [DATA_WIDTH-1:0]            i_WrData;
    logic [DATA_WIDTH-1:0]            o_RdData;
    logic                             o_RdData_valid;
    logic                             o_err;
    logic [NUM_EXPORT*DATA_WIDTH-1:0] o_regs;
    logic [NUM_EXPORT-1:0]            o_reg_upd;

    modport master (
        output i_Address, i_WrEn, i_RdEn, i_WrData,
        input  o_RdData, o_RdData_valid, o_err, o_regs, o_reg_upd
    );

    modport slave (
        input  i_Address, i_WrEn, i_RdEn, i_WrData,
        output o_RdData, o_RdData_valid, o_err, o_regs, o_reg_upd
    );
endinterface

// File: rtl/reg_rd_pipe.sv
// reg_rd_pipe
// Data/valid delay line for the read return path. Stage 0 captures the word
// sampled in the request cycle; later stages are plain registers. Each stage
// only loads data when the stage before it is valid, so the last stage holds
// the most recent result while valid is low.
//   i_clk, i_reset : clock, async active-high reset (clears valid and data)
//   i_vld, i_data  : read request strobe and the word read in that cycle
//   o_vld, o_data  : delayed strobe and data, LATENCY cycles later
module reg_rd_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_d [LATENCY];

    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        vld_d[0]  = i_vld;
        if (i_vld) begin
            data_d[0] = i_data;
        end
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) begin
                data_d[s] = data_q[s-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign o_vld  = vld_q[LATENCY-1];
    assign o_data = data_q[LATENCY-1];

endmodule

// File: rtl/reg_bank_param.sv
// reg_bank_param
// Configuration register bank: 2**ADDR_WIDTH words of DATA_WIDTH bits with
// per-word reset values (RST_VALS) and per-word write protection (RO_MASK).
// Reads return after RD_LATENCY (1 or 2) cycles, fully pipelined. A read and
// a write in the same cycle are both performed, the read seeing the old value.
// Words 0..NUM_EXPORT-1 are exported combinationally on o_regs.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : reg_bank_param_if slave (address, read/write requests, returns,
//             error strobe, exported words and update strobes)
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_EXPORT = NUM_EXPORT_DEF,
    parameter logic [depth(ADDR_WIDTH)*DATA_WIDTH-1:0] RST_VALS = RST_VALS_DEF,
    parameter logic [depth(ADDR_WIDTH)-1:0]            RO_MASK  = '0,
    parameter int RD_LATENCY = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    reg_bank_param_if.slave  bus
);

    localparam int DEPTH = depth(ADDR_WIDTH);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("reg_bank_param: RD_LATENCY must be 1 or 2");
    end
    if (NUM_EXPORT < 1 || NUM_EXPORT > DEPTH) begin : g_bad_export
        $error("reg_bank_param: NUM_EXPORT must be in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  err_q, err_d;
    logic [NUM_EXPORT-1:0] reg_upd_q, reg_upd_d;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        wr_ok = bus.i_WrEn && !RO_MASK[bus.i_Address];
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[bus.i_Address] = bus.i_WrData;
        end
        err_d = bus.i_WrEn && RO_MASK[bus.i_Address];
        // Strobe fires on every accepted write, even if the value is unchanged.
        for (int k = 0; k < NUM_EXPORT; k++) begin
            reg_upd_d[k] = wr_ok && (bus.i_Address == ADDR_WIDTH'(k));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= RST_VALS[k*DATA_WIDTH +: DATA_WIDTH];
            end
            err_q     <= 1'b0;
            reg_upd_q <= '0;
        end else begin
            mem_q     <= mem_d;
            err_q     <= err_d;
            reg_upd_q <= reg_upd_d;
        end
    end

    // Storage is sampled in the request cycle, before any same-cycle write
    // lands, which gives read-before-write for every latency.
    assign rd_word = mem_q[bus.i_Address];

    reg_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (RD_LATENCY)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_vld   (bus.i_RdEn),
        .i_data  (rd_word),
        .o_vld   (bus.o_RdData_valid),
        .o_data  (bus.o_RdData)
    );

    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
        assign bus.o_regs[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
    end

    assign bus.o_err     = err_q;
    assign bus.o_reg_upd = reg_upd_q;

endmodule
